// File: rtl/trace_buffer.sv
// Retirement-trace capture buffer with wrap, stop-when-full and PC-trigger modes.
// Frozen contents drain oldest-first through a valid/ready port.
module trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16,
  parameter int POST  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic [31:0]              commit_addr,
  input  logic [1:0]               commit_kind,
  input  logic [1:0]               mode,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     arm,
  input  logic                     stop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_data,
  output logic [31:0]              out_addr,
  output logic [1:0]               out_kind,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frozen,
  output logic                     overflow,
  output logic                     trig_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] POST_V = AW'(POST);
  localparam logic [CW-1:0] FULL_V = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAP,
    S_POST,
    S_FRZ
  } state_t;

  typedef struct packed {
    logic [1:0]      kind;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [4:0]      rd;
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  state_t          st, st_n;
  logic [AW-1:0]   wr_ptr, wr_n;
  logic [AW-1:0]   rd_ptr, rd_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   post_cnt, post_n;
  logic            ovf_n, hit_n;
  logic [1:0]      mode_q;
  logic [PC_W-1:0] trig_q;
  logic            wr_en;
  logic            full;
  logic            trig_m;
  entry_t          wr_e;
  entry_t          out_q;
  entry_t          mem [DEPTH];

  assign full   = (cnt == FULL_V);
  assign trig_m = (commit_pc == trig_q);

  assign wr_e.kind = commit_kind;
  assign wr_e.addr = commit_addr;
  assign wr_e.data = commit_data;
  assign wr_e.rd   = commit_rd;
  assign wr_e.inst = commit_inst;
  assign wr_e.pc   = commit_pc;

  // Next-state, pointer and flag update logic.
  always_comb begin
    st_n   = st;
    wr_en  = 1'b0;
    wr_n   = wr_ptr;
    rd_n   = rd_ptr;
    cnt_n  = cnt;
    post_n = post_cnt;
    ovf_n  = overflow;
    hit_n  = trig_hit;
    if (arm) begin
      st_n   = S_CAP;
      wr_n   = '0;
      rd_n   = '0;
      cnt_n  = '0;
      post_n = '0;
      ovf_n  = 1'b0;
      hit_n  = 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
        end
        S_CAP: begin
          if (commit_valid) begin
            if (full && mode_q == 2'b01) begin
              st_n = S_FRZ;
            end else begin
              wr_en = 1'b1;
              wr_n  = wr_ptr + 1'b1;
              if (full) begin
                rd_n  = rd_ptr + 1'b1;
                ovf_n = 1'b1;
              end else begin
                cnt_n = cnt + 1'b1;
              end
              if (mode_q == 2'b10 && trig_m) begin
                hit_n = 1'b1;
                if (POST == 0) begin
                  st_n = S_FRZ;
                end else begin
                  post_n = POST_V;
                  st_n   = S_POST;
                end
              end
            end
          end
          if (stop) st_n = S_FRZ;
        end
        S_POST: begin
          if (commit_valid) begin
            wr_en  = 1'b1;
            wr_n   = wr_ptr + 1'b1;
            post_n = post_cnt - 1'b1;
            if (full) begin
              rd_n  = rd_ptr + 1'b1;
              ovf_n = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
            if (post_cnt == AW'(1)) st_n = S_FRZ;
          end
          if (stop) st_n = S_FRZ;
        end
        S_FRZ: begin
          if (cnt == '0) begin
            st_n = S_IDLE;
          end else if (out_ready) begin
            rd_n  = rd_ptr + 1'b1;
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) st_n = S_IDLE;
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  // State, pointer and sticky-flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
      overflow <= 1'b0;
      trig_hit <= 1'b0;
      mode_q   <= 2'b00;
      trig_q   <= '0;
    end else begin
      st       <= st_n;
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      cnt      <= cnt_n;
      post_cnt <= post_n;
      overflow <= ovf_n;
      trig_hit <= hit_n;
      if (arm) begin
        mode_q <= (mode == 2'b11) ? 2'b00 : mode;
        trig_q <= trig_pc;
      end
    end
  end

  // Entry storage; no reset needed, contents are qualified by count.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_ptr] <= wr_e;
  end

  // Registered read port; bypasses a same-edge write into the head slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= '0;
    end else if (st_n == S_FRZ && cnt_n != '0) begin
      if (wr_en && wr_ptr == rd_n) out_q <= wr_e;
      else                         out_q <= mem[rd_n];
    end else begin
      out_q <= '0;
    end
  end

  assign frozen    = (st == S_FRZ);
  assign out_valid = frozen && (cnt != '0);
  assign count     = cnt;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;
  assign out_rd    = out_q.rd;
  assign out_data  = out_q.data;
  assign out_addr  = out_q.addr;
  assign out_kind  = out_q.kind;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer (DEPTH=4, POST=2).
// Hand-computed expectations, immediate assertions at each check.
module tb_trace_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        commit_valid;
  logic [15:0] commit_pc;
  logic [31:0] commit_inst;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [31:0] commit_addr;
  logic [1:0]  commit_kind;
  logic [1:0]  mode;
  logic [15:0] trig_pc;
  logic        arm;
  logic        stop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic [1:0]  out_kind;
  logic [2:0]  count;
  logic        frozen;
  logic        overflow;
  logic        trig_hit;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_pc [4];

  trace_buffer #(.DEPTH(4), .PC_W(16), .POST(2)) dut (
    .CLK(CLK), .RST(RST),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_addr(commit_addr),
    .commit_kind(commit_kind), .mode(mode), .trig_pc(trig_pc),
    .arm(arm), .stop(stop), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(out_rd), .out_data(out_data), .out_addr(out_addr),
    .out_kind(out_kind), .count(count), .frozen(frozen),
    .overflow(overflow), .trig_hit(trig_hit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [15:0] tp);
    mode = m;
    trig_pc = tp;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_commit(input logic [15:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_inst  = {16'h0013, pc};
    commit_rd    = pc[6:2];
    commit_data  = {16'hd000, pc};
    commit_addr  = 32'h0;
    commit_kind  = 2'd1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, 32'(out_pc), 32'(exp_pc[i]));
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_cnt"}, 32'(count), 32'd0);
  endtask

  initial begin
    int idx;
    logic [3:0] pat;
    RST = 1'b1;
    commit_valid = 1'b0;
    commit_pc = '0;
    commit_inst = '0;
    commit_rd = '0;
    commit_data = '0;
    commit_addr = '0;
    commit_kind = '0;
    mode = 2'b00;
    trig_pc = '0;
    arm = 1'b0;
    stop = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_hit", 32'(trig_hit), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);

    // idle ignores commits
    do_commit(16'h0abc);
    chk("idle_cnt", 32'(count), 32'd0);

    // wrap mode
    do_arm(2'b00, 16'h0);
    for (int i = 0; i < 6; i++) do_commit(16'(i * 4));
    chk("wrap_cnt_pre", 32'(count), 32'd4);
    chk("wrap_frozen_pre", 32'(frozen), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wrap_frozen", 32'(frozen), 32'd1);
    chk("wrap_cnt", 32'(count), 32'd4);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    exp_pc[0] = 16'h08; exp_pc[1] = 16'h0c;
    exp_pc[2] = 16'h10; exp_pc[3] = 16'h14;
    drain(4, "wrap");
    chk("wrap_idle", 32'(frozen), 32'd0);

    // stop-when-full
    do_arm(2'b01, 16'h0);
    for (int i = 0; i < 4; i++) do_commit(16'h100 + 16'(i * 4));
    chk("swf_cnt4", 32'(count), 32'd4);
    chk("swf_not_frozen", 32'(frozen), 32'd0);
    do_commit(16'h110);
    chk("swf_frozen", 32'(frozen), 32'd1);
    chk("swf_cnt", 32'(count), 32'd4);
    chk("swf_ovf", 32'(overflow), 32'd0);
    exp_pc[0] = 16'h100; exp_pc[1] = 16'h104;
    exp_pc[2] = 16'h108; exp_pc[3] = 16'h10c;
    drain(4, "swf");

    // trigger mode, POST=2
    do_arm(2'b10, 16'h0040);
    for (int i = 0; i < 6; i++) do_commit(16'h30 + 16'(i * 4));
    chk("trg_pre_frozen", 32'(frozen), 32'd0);
    chk("trg_hit_pre", 32'(trig_hit), 32'd1);
    do_commit(16'h48);
    chk("trg_frozen", 32'(frozen), 32'd1);
    chk("trg_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) do_commit(16'h4c + 16'(i * 4));
    chk("trg_nowrite_cnt", 32'(count), 32'd4);
    chk("trg_nowrite_pc", 32'(out_pc), 32'h3c);
    exp_pc[0] = 16'h3c; exp_pc[1] = 16'h40;
    exp_pc[2] = 16'h44; exp_pc[3] = 16'h48;
    drain(4, "trg");

    // backpressure: ready pattern 1,0,0,1
    do_arm(2'b00, 16'h0);
    for (int i = 0; i < 4; i++) do_commit(16'h500 + 16'(i * 4));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pat = 4'b1001;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc", 32'(out_pc), 32'h500 + 32'(idx * 4));
      chk("bp_data", out_data, 32'hd0000500 + 32'(idx * 4));
      chk("bp_cnt", 32'(count), 32'(4 - idx));
      out_ready = pat[3 - (c % 4)];
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    chk("bp_all_seen", 32'(idx), 32'd4);
    chk("bp_idle", 32'(frozen), 32'd0);

    // arm with same-cycle commit
    do_arm(2'b00, 16'h0);
    do_commit(16'h600);
    do_commit(16'h604);
    commit_valid = 1'b1;
    commit_pc = 16'h608;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    commit_valid = 1'b0;
    chk("armc_cnt", 32'(count), 32'd0);
    chk("armc_frozen", 32'(frozen), 32'd0);

    // stop with same-cycle commit
    do_commit(16'h200);
    stop = 1'b1;
    do_commit(16'h204);
    stop = 1'b0;
    chk("stopc_frozen", 32'(frozen), 32'd1);
    chk("stopc_cnt", 32'(count), 32'd2);
    exp_pc[0] = 16'h200; exp_pc[1] = 16'h204;
    drain(2, "stopc");

    // store record, then reset mid-drain
    do_arm(2'b00, 16'h0);
    commit_valid = 1'b1;
    commit_pc    = 16'h0300;
    commit_inst  = 32'h0ab12023;
    commit_rd    = 5'd0;
    commit_data  = 32'h000000ab;
    commit_addr  = 32'h0000f95c;
    commit_kind  = 2'd3;
    tick();
    commit_valid = 1'b0;
    do_commit(16'h0304);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("st_pc", 32'(out_pc), 32'h0300);
    chk("st_inst", out_inst, 32'h0ab12023);
    chk("st_rd", 32'(out_rd), 32'd0);
    chk("st_data", out_data, 32'h000000ab);
    chk("st_addr", out_addr, 32'h0000f95c);
    chk("st_kind", 32'(out_kind), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("st_next_pc", 32'(out_pc), 32'h0304);
    chk("st_next_cnt", 32'(count), 32'd1);
    out_ready = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstd_valid", 32'(out_valid), 32'd0);
    chk("rstd_cnt", 32'(count), 32'd0);
    chk("rstd_frozen", 32'(frozen), 32'd0);
    chk("rstd_pc", 32'(out_pc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
